exe_mem_pipe_stage: RTL and testbench

- Parametrised successor to the fixed EXE->MEM pipeline register.
- Carries the EXE result bundle (wb/mem-read/mem-write enables, ALU result, dest register, store data) into MEM as an elastic stage.
- Uses a valid/ready handshake and a 2-entry skid buffer, so a MEM-side stall (e.g. slow SRAM) never forces a combinational ready path back into EXE.
- Supports the legacy global freeze plus a new synchronous flush.

---
 rtl/exe_mem_pipe_stage.sv | 151 +++++++++++++++
 tb/tb_exe_mem_pipe_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Optional stall/bubble performance counters are enabled by defining EXE_MEM_PERF_CNT_EN.
module exe_mem_pipe_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEST_W = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic              in_mem_w_en,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DEST_W-1:0] in_dest,
   input  logic [DATA_W-1:0] in_val_rm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r_en,
   output logic              out_mem_w_en,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DEST_W-1:0] out_dest,
   output logic [DATA_W-1:0] out_val_rm,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [DATA_W-1:0] alu_result;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] val_rm;
   } bundle_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t  r_state, w_next_state;
   bundle_t r_main, r_skid, w_in_bundle;
   logic    r_in_ready;
   logic    w_in_fire, w_out_fire, w_out_valid;
   logic    w_load_main_in, w_load_main_skid, w_load_skid;

   assign w_in_bundle = '{wb_en: in_wb_en, mem_r_en: in_mem_r_en, mem_w_en: in_mem_w_en,
                          alu_result: in_alu_result, dest: in_dest, val_rm: in_val_rm};

   // Ready comes from a flop; freeze only masks it, so no path from out_ready reaches EXE.
   assign in_ready    = r_in_ready & ~freeze;
   assign w_out_valid = (r_state != EMPTY) & ~freeze;
   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = w_out_valid & out_ready;

   always_comb begin
      w_next_state     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_next_state = EMPTY;
      end else if (!freeze) begin
         unique case (r_state)
            EMPTY: if (w_in_fire) begin
               w_next_state   = ONE;
               w_load_main_in = 1'b1;
            end
            ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main_in = 1'b1;
               end else if (w_in_fire) begin
                  w_next_state = FULL;
                  w_load_skid  = 1'b1;
               end else if (w_out_fire) begin
                  w_next_state = EMPTY;
               end
            end
            FULL: if (w_out_fire) begin
               w_next_state     = ONE;
               w_load_main_skid = 1'b1;
            end
            default: w_next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != FULL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= w_in_bundle;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_bundle;
         end else if (w_load_main_skid) begin
            r_skid <= '0;
         end
      end
   end

   assign out_valid      = w_out_valid;
   assign out_wb_en      = w_out_valid & r_main.wb_en;
   assign out_mem_r_en   = w_out_valid & r_main.mem_r_en;
   assign out_mem_w_en   = w_out_valid & r_main.mem_w_en;
   assign out_alu_result = r_main.alu_result;
   assign out_dest       = r_main.dest;
   assign out_val_rm     = r_main.val_rm;

`ifdef EXE_MEM_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

   // Saturating counters; flush deliberately leaves them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (!freeze && !w_out_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Self-checking bench for exe_mem_pipe_stage: directed scenarios plus randomized
// traffic checked against a queue-based FIFO model of capacity two.
module tb_exe_mem_pipe_stage;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEST_W = 4;
   localparam int unsigned CNT_W  = 16;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [DATA_W-1:0] alu_result;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] val_rm;
   } bundle_t;

   logic              clk = 1'b0;
   logic              rst, flush, freeze, in_valid, in_ready, out_valid, out_ready;
   logic              in_wb_en, in_mem_r_en, in_mem_w_en;
   logic              out_wb_en, out_mem_r_en, out_mem_w_en;
   logic [DATA_W-1:0] in_alu_result, in_val_rm, out_alu_result, out_val_rm;
   logic [DEST_W-1:0] in_dest, out_dest;
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   exe_mem_pipe_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
      .in_alu_result(in_alu_result), .in_dest(in_dest), .in_val_rm(in_val_rm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
      .out_alu_result(out_alu_result), .out_dest(out_dest), .out_val_rm(out_val_rm),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   task automatic idle_inputs();
      flush = 0; freeze = 0; in_valid = 0; out_ready = 0;
      in_wb_en = 0; in_mem_r_en = 0; in_mem_w_en = 0;
      in_alu_result = '0; in_dest = '0; in_val_rm = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      else n_pass++;
      tick();
      in_valid = 1; in_mem_w_en = 1; in_alu_result = 32'h1234; tick();
      in_alu_result = 32'h5678; tick();
      in_valid = 0; in_mem_w_en = 0;
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || out_alu_result !== 32'h1234) $display("FAIL full_before_rst out_valid=%b alu=%h required 1/1234", out_valid, out_alu_result);
      else n_pass++;
      rst = 1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_mem_w_en !== 1'b0 || out_alu_result !== '0)
         $display("FAIL async_rst out_valid=%b mem_w_en=%b alu=%h required 0/0/0", out_valid, out_mem_w_en, out_alu_result);
      else n_pass++;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL post_rst in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_stream();
      apply_reset();
      out_ready = 1;
      for (int k = 0; k <= 8; k++) begin
         in_valid = (k < 8);
         in_alu_result = 32'h10 + k;
         @(negedge clk);
         n_checks++;
         if (k == 0) begin
            if (out_valid !== 1'b0) $display("FAIL stream_latency out_valid=%b required 0", out_valid);
            else n_pass++;
         end else begin
            if (out_valid !== 1'b1 || out_alu_result !== 32'h10 + k - 1 || (k < 8 && in_ready !== 1'b1))
               $display("FAIL stream_%0d out_valid=%b alu=%h in_ready=%b required 1/%h/1", k, out_valid, out_alu_result, in_ready, 32'h10 + k - 1);
            else n_pass++;
         end
         tick();
      end
      in_valid = 0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL stream_drain out_valid=%b required 0", out_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] vals [3];
      logic [DATA_W-1:0] got [$];
      int sent = 0;
      vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
      apply_reset();
      for (int cyc = 0; cyc < 12; cyc++) begin
         logic acc;
         in_valid = (sent < 3);
         in_alu_result = (sent < 3) ? vals[sent] : '0;
         out_ready = (cyc >= 3);
         @(negedge clk);
         if (cyc == 2) begin
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_hold in_ready=%b required 0", in_ready);
            else n_pass++;
         end
         acc = in_valid && in_ready;
         if (out_valid && out_ready) got.push_back(out_alu_result);
         tick();
         if (acc) sent++;
      end
      in_valid = 0;
      n_checks++;
      if (got.size() != 3) $display("FAIL bp_count delivered=%0d required 3", got.size());
      else n_pass++;
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== vals[i]) $display("FAIL bp_order_%0d got=%h required %h", i, got[i], vals[i]);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      apply_reset();
      in_valid = 1; in_alu_result = 32'h1; tick();
      in_alu_result = 32'h2; tick();
      in_alu_result = 32'hD; flush = 1; tick();
      flush = 0; in_valid = 0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_clear out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      else n_pass++;
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL flush_leak_%0d out_valid=%b alu=%h required 0", i, out_valid, out_alu_result);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_freeze();
      apply_reset();
      in_valid = 1; in_dest = 4'd5; in_mem_r_en = 1; in_alu_result = 32'h77; tick();
      in_dest = 4'd9; in_mem_r_en = 0; in_alu_result = 32'h99;
      freeze = 1; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_mem_r_en !== 1'b0)
            $display("FAIL freeze_%0d out_valid=%b in_ready=%b mem_r_en=%b required 0/0/0", i, out_valid, in_ready, out_mem_r_en);
         else n_pass++;
         tick();
      end
      freeze = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_dest !== 4'd5 || out_mem_r_en !== 1'b1 || out_alu_result !== 32'h77 || in_ready !== 1'b1)
         $display("FAIL unfreeze out_valid=%b dest=%0d mem_r_en=%b alu=%h in_ready=%b required 1/5/1/77/1",
                  out_valid, out_dest, out_mem_r_en, out_alu_result, in_ready);
      else n_pass++;
      out_ready = 1; tick();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL freeze_dup out_valid=%b required 0", out_valid);
      else n_pass++;
      tick();
   endtask

   task automatic test_perf();
      logic [CNT_W-1:0] exp_s, exp_b;
`ifdef EXE_MEM_PERF_CNT_EN
      exp_s = 4; exp_b = 2;
`else
      exp_s = 0; exp_b = 0;
`endif
      apply_reset();
      out_ready = 1; tick();
      in_valid = 1; in_alu_result = 32'h42; tick();
      in_valid = 0; out_ready = 0;
      repeat (4) tick();
      out_ready = 1; tick();
      freeze = 1;
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== exp_s || bubble_cnt !== exp_b)
         $display("FAIL perf_counts stall=%0d bubble=%0d required %0d/%0d", stall_cnt, bubble_cnt, exp_s, exp_b);
      else n_pass++;
      tick();
      freeze = 0;
   endtask

   task automatic test_random();
      bundle_t q [$];
      bundle_t cur, seen;
      logic exp_rdy, exp_ov, infire, outfire;
      int exp_stall = 0, exp_bub = 0;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         cur = '{wb_en: 1'($urandom), mem_r_en: 1'($urandom), mem_w_en: 1'($urandom),
                 alu_result: $urandom, dest: 4'($urandom_range(0, 15)), val_rm: $urandom};
         in_valid = 1'($urandom_range(0, 1));
         {in_wb_en, in_mem_r_en, in_mem_w_en} = {cur.wb_en, cur.mem_r_en, cur.mem_w_en};
         in_alu_result = cur.alu_result; in_dest = cur.dest; in_val_rm = cur.val_rm;
         out_ready = ($urandom_range(0, 3) != 0);
         freeze = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         exp_rdy = (q.size() < 2) && !freeze;
         exp_ov = (q.size() > 0) && !freeze;
         n_checks++;
         if (in_ready !== exp_rdy || out_valid !== exp_ov)
            $display("FAIL rnd_hs_%0d in_ready=%b out_valid=%b required %b/%b", c, in_ready, out_valid, exp_rdy, exp_ov);
         else n_pass++;
         seen = '{wb_en: out_wb_en, mem_r_en: out_mem_r_en, mem_w_en: out_mem_w_en,
                  alu_result: out_alu_result, dest: out_dest, val_rm: out_val_rm};
         n_checks++;
         if (exp_ov) begin
            if (seen !== q[0]) $display("FAIL rnd_data_%0d got=%h required %h", c, seen, q[0]);
            else n_pass++;
         end else begin
            if ({out_wb_en, out_mem_r_en, out_mem_w_en} !== 3'b000)
               $display("FAIL rnd_en_%0d enables=%b required 000", c, {out_wb_en, out_mem_r_en, out_mem_w_en});
            else n_pass++;
         end
         n_checks++;
         if (stall_cnt !== CNT_W'(exp_stall) || bubble_cnt !== CNT_W'(exp_bub))
            $display("FAIL rnd_cnt_%0d stall=%0d bubble=%0d required %0d/%0d", c, stall_cnt, bubble_cnt, exp_stall, exp_bub);
         else n_pass++;
         infire = in_valid && exp_rdy;
         outfire = exp_ov && out_ready;
`ifdef EXE_MEM_PERF_CNT_EN
         if (exp_ov && !out_ready) exp_stall++;
         if (!freeze && !exp_ov) exp_bub++;
`endif
         @(posedge clk);
         if (flush) q.delete();
         else begin
            if (outfire) void'(q.pop_front());
            if (infire) q.push_back(cur);
         end
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_freeze();
      test_perf();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
